// File: rtl/muldiv_e_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Stalls the pipeline while it iterates, then presents a one-cycle result.
module muldiv_e_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic        KillE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic        StallMD,
  output logic        DoneMD,
  output logic [31:0] ResultMD
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opa;
  logic        neg_a, neg_b;
  logic [2:0]  f3;

  logic        a_sgn, b_sgn, a_neg_in, b_neg_in;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, fast;
  logic [31:0] fast_result;
  logic        accept, last;

  logic [32:0] mul_sum;
  logic [63:0] mul_step, prod;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_step;
  logic [31:0] quo, rem, mul_res, div_res;

  // Operand decode for the accepting cycle
  always_comb begin
    a_sgn       = Funct3E[2] ? ~Funct3E[0] : (Funct3E[1:0] != 2'b11);
    b_sgn       = Funct3E[2] ? ~Funct3E[0] : ~Funct3E[1];
    a_neg_in    = a_sgn & SrcAE[31];
    b_neg_in    = b_sgn & SrcBE[31];
    a_mag       = a_neg_in ? -SrcAE : SrcAE;
    b_mag       = b_neg_in ? -SrcBE : SrcBE;
    div_zero    = (SrcBE == '0);
    div_ovf     = ~Funct3E[0] & (SrcAE == 32'h8000_0000) & (SrcBE == '1);
    fast        = Funct3E[2] & (div_zero | div_ovf);
    fast_result = div_zero ? (Funct3E[1] ? SrcAE : '1)
                           : (Funct3E[1] ? '0 : 32'h8000_0000);
    accept      = (state == IDLE) & StartE & ~KillE;
    last        = (cnt == 6'd31);
  end

  // One iteration step; acc holds {hi, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    mul_step  = {mul_sum, acc[31:1]};
    prod      = (neg_a ^ neg_b) ? -mul_step : mul_step;
    mul_res   = (f3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, opa};
    div_step  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                             : {div_diff[31:0],  acc[30:0], 1'b1};
    quo       = div_step[31:0];
    rem       = div_step[63:32];
    div_res   = f3[1] ? (neg_a ? -rem : rem)
                      : ((neg_a ^ neg_b) ? -quo : quo);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (StartE) state_next = !Funct3E[2] ? MUL : (fast ? DONE : DIV);
      MUL:  if (last)   state_next = DONE;
      DIV:  if (last)   state_next = DONE;
      DONE:             state_next = IDLE;
      default:          state_next = IDLE;
    endcase
    if (KillE) state_next = IDLE;
  end

  always_comb begin
    StallMD = accept | (state == MUL) | (state == DIV);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      opa      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      f3       <= '0;
      DoneMD   <= 1'b0;
      ResultMD <= '0;
    end else begin
      DoneMD <= (state_next == DONE);
      if (KillE) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        f3    <= Funct3E;
        neg_a <= a_neg_in;
        neg_b <= b_neg_in;
        opa   <= Funct3E[2] ? b_mag : a_mag;
        acc   <= {32'd0, Funct3E[2] ? a_mag : b_mag};
        if (fast) ResultMD <= fast_result;
      end else if (state == MUL) begin
        acc <= mul_step;
        cnt <= cnt + 6'd1;
        if (last) ResultMD <= mul_res;
      end else if (state == DIV) begin
        acc <= div_step;
        cnt <= cnt + 6'd1;
        if (last) ResultMD <= div_res;
      end
    end
  end

endmodule
